mult_share_arbiter: RTL and testbench

- Shares one combinational unsigned WIDTH x WIDTH multiplier among NUM_REQ requesters.
- Round-robin arbitration selects a requester; its operands are captured and the product is registered.
- The result is returned on a single response channel tagged with the requester index.
- Sits between the compute clients and the multiplier datapath; it is the only block that drives the multiplier inputs.

---
 rtl/mult_share_pkg.sv | 14 +
 rtl/mult_share_rr_arbiter.sv | 40 ++++
 rtl/mult_share_arbiter.sv | 119 +++++++++++
 tb/tb_mult_share_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and default sizing for the shared-multiplier arbiter.
package mult_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  // Controller phases: wait for a grant, compute, hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_share_rr_arbiter.sv
// Combinational round-robin picker: the first set request bit at or after
// ptr, wrapping modulo NUM_REQ. Produces one-hot and encoded grants.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one unsigned WIDTH x WIDTH multiplier among NUM_REQ requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands stable until accepted; the
// response holds rsp_valid/rsp_id/rsp_p stable until rsp_ready is seen.
// One request is in flight at a time: IDLE grants, CALC registers the
// product, RESP waits for the consumer.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_p
);

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    op_id;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [ID_W-1:0]    next_ptr;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2*WIDTH-1:0] mult_p;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Offer the grant only in IDLE; reset forces ready low even with valids up.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE)) begin
      req_ready = grant;
    end
  end

  assign accept = rst_n && (state == IDLE) && grant_any;

  // Pointer moves one past the winner so it becomes lowest priority next.
  assign next_ptr = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // The shared multiplier: full-width unsigned product of the captured operands.
  assign mult_p = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  // Controller and registered response; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_p     <= mult_p;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked by a cycle monitor whose
// expectations come from the grant/latency rules of the block.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  localparam int N   = DEF_NUM_REQ;
  localparam int W   = DEF_WIDTH;
  localparam int IW  = $clog2(N);
  localparam int TMO = 50;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [2*W-1:0]    rsp_p;

  int n_vec;
  int n_err;

  // Reference model state: expected responses in order, plus busy tracking.
  logic [IW+2*W-1:0] exp_q[$];
  bit                m_busy;
  int                m_age;
  int                m_ptr;

  typedef struct {
    int idx;
    int a;
    int b;
    int exp_id;
    int exp_p;
  } vec_t;

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t: no handshake within %0d cycles", name, $time, TMO);
  endtask

  // First valid requester at or after ptr, wrapping; -1 if none.
  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int opnd(input logic [N*W-1:0] bus, input int i);
    return int'(bus[i*W +: W]);
  endfunction

  // Monitor / scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int g;
    int prod;
    exp_ready = '0;
    g = -1;
    if (!rst_n) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_p", 32'(rsp_p), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      m_busy = 1'b0;
      m_age  = 0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      if (!m_busy) begin
        g = model_grant(req_valid, m_ptr);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_model at %0t: response expected but model queue empty", $time);
        end else begin
          check("rsp_id", 32'(rsp_id), 32'(exp_q[0][2*W +: IW]));
          check("rsp_p", 32'(rsp_p), 32'(exp_q[0][2*W-1:0]));
        end
      end
      // Advance the model across the coming rising edge.
      if (m_busy) begin
        if (m_age >= 2 && rsp_ready) begin
          m_busy = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (m_age < 2) begin
          m_age++;
        end
      end else if (g >= 0) begin
        prod = opnd(req_a, g) * opnd(req_b, g);
        exp_q.push_back({IW'(g), (2*W)'(prod)});
        m_ptr  = (g + 1) % N;
        m_busy = 1'b1;
        m_age  = 1;
      end
    end
  end

  // Driver tasks: all called and returning at posedge + #1.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_accept(input int i);
    int t = 0;
    @(negedge clk);
    while (!(req_valid[i] && req_ready[i]) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout_fail("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i]    = 1'b1;
    wait_accept(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int id, output int p);
    int t = 0;
    @(negedge clk);
    while (!(rsp_valid && rsp_ready) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      timeout_fail("rsp_timeout");
      id = -1;
      p  = -1;
    end else begin
      id = int'(rsp_id);
      p  = int'(rsp_p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int i, input int a, input int b, output int id, output int p);
    rsp_ready = 1'b1;
    issue(i, a, b);
    wait_rsp(id, p);
  endtask

  initial begin
    vec_t         vecs[6];
    int           id;
    int           p;
    int           seen;
    logic [N-1:0] acc;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;

    // Reset and idle: monitor checks outputs during reset and 20 idle cycles.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Single-request vectors, including max and zero operands.
    vecs[0] = '{idx: 2, a: 13, b: 11, exp_id: 2, exp_p: 143};
    vecs[1] = '{idx: 0, a: 15, b: 15, exp_id: 0, exp_p: 225};
    vecs[2] = '{idx: 3, a: 0,  b: 9,  exp_id: 3, exp_p: 0};
    vecs[3] = '{idx: 1, a: 7,  b: 0,  exp_id: 1, exp_p: 0};
    vecs[4] = '{idx: 0, a: 1,  b: 1,  exp_id: 0, exp_p: 1};
    vecs[5] = '{idx: 3, a: 15, b: 1,  exp_id: 3, exp_p: 15};
    for (int v = 0; v < 6; v++) begin
      run_one(vecs[v].idx, vecs[v].a, vecs[v].b, id, p);
      check($sformatf("vec%0d_id", v), 32'(id), 32'(vecs[v].exp_id));
      check($sformatf("vec%0d_p", v), 32'(p), 32'(vecs[v].exp_p));
    end

    // Round-robin with all four valid: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(3);
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(id, p);
      check($sformatf("rr%0d_id", k), 32'(id), 32'(k % N));
      check($sformatf("rr%0d_p", k), 32'(p), 32'(3 * ((k % N) + 1)));
    end
    req_valid = '0;

    // Backpressure: 15*15 held for 5 cycles while another requester waits.
    rsp_ready = 1'b0;
    issue(1, 15, 15);
    seen = 0;
    while (!rsp_valid && seen < TMO) begin
      @(negedge clk);
      seen++;
    end
    if (seen >= TMO) timeout_fail("bp_rsp_timeout");
    @(posedge clk);
    #1;
    req_a[0 +: W] = W'(2);
    req_b[0 +: W] = W'(2);
    req_valid[0]  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_p", 32'(rsp_p), 32'hE1);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp(id, p);
    check("bp_rel_id", 32'(id), 32'd1);
    check("bp_rel_p", 32'(p), 32'hE1);
    @(negedge clk);
    check("retain_p", 32'(rsp_p), 32'hE1);
    check("retain_id", 32'(rsp_id), 32'd1);
    @(posedge clk);
    #1;
    if (req_valid[0] && !m_busy) wait_accept(0);
    req_valid[0] = 1'b0;
    wait_rsp(id, p);
    check("bp_next_id", 32'(id), 32'd0);
    check("bp_next_p", 32'(p), 32'd4);

    // Wrap and gap: pointer at 3, requests on 1 and 3 -> 3,1,3.
    do_reset();
    run_one(2, 5, 5, id, p);
    check("wrap_pre_p", 32'(p), 32'd25);
    req_a[1*W +: W] = W'(2);
    req_b[1*W +: W] = W'(5);
    req_a[3*W +: W] = W'(3);
    req_b[3*W +: W] = W'(5);
    req_valid = 4'b1010;
    wait_rsp(id, p);
    check("wrap0_id", 32'(id), 32'd3);
    check("wrap0_p", 32'(p), 32'd15);
    wait_rsp(id, p);
    check("wrap1_id", 32'(id), 32'd1);
    check("wrap1_p", 32'(p), 32'd10);
    wait_rsp(id, p);
    check("wrap2_id", 32'(id), 32'd3);
    check("wrap2_p", 32'(p), 32'd15);
    req_valid = '0;

    // Single requester 0 repeatedly.
    for (int k = 0; k < 3; k++) begin
      run_one(0, k + 2, 3, id, p);
      check($sformatf("solo%0d_id", k), 32'(id), 32'd0);
      check($sformatf("solo%0d_p", k), 32'(p), 32'(3 * (k + 2)));
    end

    // Reset mid-operation with 9*7 pending in CALC.
    issue(2, 9, 7);
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rsp_p", 32'(rsp_p), 32'd0);
    check("async_rsp_id", 32'(rsp_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("post_rst_no_rsp", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    req_a[1*W +: W] = W'(4);
    req_b[1*W +: W] = W'(4);
    req_a[3*W +: W] = W'(5);
    req_b[3*W +: W] = W'(5);
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    wait_rsp(id, p);
    check("post_rst_id", 32'(id), 32'd1);
    check("post_rst_p", 32'(p), 32'd16);
    req_valid = '0;

    // Randomized traffic checked by the monitor.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i]    = 1'b1;
            req_a[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
            req_b[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    // Drain: let any outstanding request complete.
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    rsp_ready = 1'b1;
    repeat (4 * N + 10) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
    end
    check("drain_idle", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
